// File: rtl/instr_pkg.sv
// rtl/instr_pkg.sv - shared instruction encoding for the feeder and FIFO/ALU block
package instr_pkg;

    localparam int IW = 12;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_MUL = 4'h2;
    localparam logic [3:0] OP_DIV = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_OR  = 4'h5;
    localparam logic [3:0] OP_XOR = 4'h6;
    localparam logic [3:0] OP_NOT = 4'h7;
    localparam logic [3:0] OP_SHR = 4'h8;
    localparam logic [3:0] OP_SHL = 4'h9;

    // 0xA..0xF are reserved and never reach the FIFO
    localparam logic [3:0] OP_MAX_VALID = 4'h9;

    localparam int OPC_MSB = 11;
    localparam int OPC_LSB = 8;
    localparam int A_MSB   = 7;
    localparam int A_LSB   = 4;
    localparam int B_MSB   = 3;
    localparam int B_LSB   = 0;

endpackage

// File: rtl/instr_prog_mem.sv
// rtl/instr_prog_mem.sv - program register array, one write port, async read port
module instr_prog_mem #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int IW    = 12
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [IW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [IW-1:0] o_rdata
);

    // No reset: program contents survive rst so a restart replays them
    logic [IW-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/instr_feeder.sv
// rtl/instr_feeder.sv - streams a loadable instruction program into the FIFO write port
module instr_feeder #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int IW    = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [IW-1:0] prog_data,
    input  logic [AW-1:0] prog_len,
    input  logic [3:0]    reps,
    input  logic          start,
    input  logic          stop,
    input  logic          fifo_full,
    output logic          wr_en,
    output logic [IW-1:0] instruction,
    output logic          busy,
    output logic          done,
    output logic [7:0]    issued_count,
    output logic [3:0]    skip_count
);

    import instr_pkg::*;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]    r_state;
    logic [AW-1:0] r_ptr;
    logic [AW-1:0] r_len;
    logic [3:0]    r_rep;
    logic [3:0]    r_pass;
    logic [7:0]    r_issued;
    logic [3:0]    r_skip;
    logic          r_busy;
    logic          r_done;

    logic          w_run;
    logic [IW-1:0] w_rd;
    logic          w_valid;
    logic          w_wr;
    logic          w_adv;
    logic          w_last;

    instr_prog_mem #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .IW    (IW)
    ) u_mem (
        .clk     (clk),
        .i_we    (prog_we & ~w_run),
        .i_waddr (prog_addr),
        .i_wdata (prog_data),
        .i_raddr (r_ptr),
        .o_rdata (w_rd)
    );

    assign w_run   = (r_state == S_RUN);
    assign w_valid = (w_rd[OPC_MSB:OPC_LSB] <= OP_MAX_VALID);
    // rst gates the write combinationally so an aborting edge never commits one
    assign w_wr    = w_run & w_valid & ~fifo_full & ~stop & ~rst;
    assign w_adv   = w_run & ~stop & (w_wr | ~w_valid);
    assign w_last  = (r_ptr == r_len);

    assign wr_en        = w_wr;
    assign instruction  = w_run ? w_rd : '0;
    assign busy         = r_busy;
    assign done         = r_done;
    assign issued_count = r_issued;
    assign skip_count   = r_skip;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_ptr    <= '0;
            r_len    <= '0;
            r_rep    <= '0;
            r_pass   <= '0;
            r_issued <= '0;
            r_skip   <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state  <= S_RUN;
                        r_busy   <= 1'b1;
                        r_len    <= prog_len;
                        r_rep    <= reps;
                        r_ptr    <= '0;
                        r_pass   <= '0;
                        r_issued <= '0;
                        r_skip   <= '0;
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_adv) begin
                        if (w_valid) begin
                            if (r_issued != 8'hFF) r_issued <= r_issued + 8'd1;
                        end else begin
                            if (r_skip != 4'hF) r_skip <= r_skip + 4'd1;
                        end
                        if (w_last) begin
                            r_ptr  <= '0;
                            r_pass <= r_pass + 4'd1;
                            if (r_pass == r_rep) begin
                                r_state <= S_IDLE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end
                        end else begin
                            r_ptr <= r_ptr + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
